// File: rtl/nanov_serial_harness.sv
// Framed serial load / execute / unload harness around a bit-serial nanoV core.
// Optional build macro: SERIAL_PARITY_EN (trailing even-parity bit on each input frame).
module nanov_serial_harness #(
  parameter int XLEN        = 32,
  parameter int OP_W        = 4,
  parameter int EXEC_CYCLES = 32
) (
  input  logic            clk12MHz,
  input  logic            rst,
  input  logic            sin,
  input  logic            sin_valid,
  input  logic            abort,
  output logic [OP_W-1:0] op_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic            start_o,
  input  logic [XLEN-1:0] d_i,
  output logic            sout,
  output logic            sout_valid,
  output logic            busy,
  output logic            ovr,
  output logic            err,
  output logic [1:0]      state_dbg
);

  localparam int PAY = OP_W + 2 * XLEN;
`ifdef SERIAL_PARITY_EN
  localparam int FRAME_BITS = PAY + 1;
`else
  localparam int FRAME_BITS = PAY;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int EC_W  = $clog2(EXEC_CYCLES + 1);

  // Handshake: sin is consumed on every cycle sin_valid=1 in IDLE/LOAD; no backpressure,
  // a bit offered in EXEC/UNLOAD is dropped and flagged in ovr.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXEC   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [EC_W-1:0]   ecnt;
  logic [PAY-1:0]    shadow, payload_nx;
  logic [XLEN-1:0]   cap, osh;
  logic              accept, frame_done, parity_ok, load_ok, exec_done, unload_done;

`ifdef SERIAL_PARITY_EN
  // The parity bit itself is never shifted in; shadow already holds the full payload.
  assign payload_nx = shadow;
  assign parity_ok  = ~(^shadow ^ sin);
`else
  assign payload_nx = (shadow << 1) | PAY'(sin);
  assign parity_ok  = 1'b1;
`endif

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    accept      = sin_valid && (state == S_IDLE || state == S_LOAD);
    cnt_nx      = (state == S_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    frame_done  = accept && (cnt_nx == CNT_W'(FRAME_BITS));
    load_ok     = frame_done && parity_ok;
    exec_done   = (state == S_EXEC) && (ecnt == '0);
    unload_done = (state == S_UNLOAD) && (cnt == CNT_W'(XLEN));
  end

  always_ff @(posedge clk12MHz) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (frame_done)  state_nx = load_ok ? S_EXEC : S_IDLE;
          else if (accept) state_nx = S_LOAD;
        end
        S_EXEC:   if (exec_done)   state_nx = S_UNLOAD;
        S_UNLOAD: if (unload_done) state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      cnt        <= '0;
      ecnt       <= '0;
      shadow     <= '0;
      op_o       <= '0;
      a_o        <= '0;
      b_o        <= '0;
      cap        <= '0;
      osh        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      start_o    <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (sin_valid && (state == S_EXEC || state == S_UNLOAD)) ovr <= 1'b1;
      if (abort) begin
        cnt        <= '0;
        ecnt       <= '0;
        sout_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_LOAD: begin
            if (accept) begin
              cnt <= cnt_nx;
              if (cnt_nx <= CNT_W'(PAY)) shadow <= (shadow << 1) | PAY'(sin);
              if (load_ok) begin
                op_o    <= payload_nx[PAY-1 -: OP_W];
                a_o     <= payload_nx[2*XLEN-1 -: XLEN];
                b_o     <= payload_nx[XLEN-1:0];
                start_o <= 1'b1;
                ecnt    <= EC_W'(EXEC_CYCLES);
              end
            end
          end
          S_EXEC: begin
            if (exec_done) begin
              cap        <= d_i;
              osh        <= d_i << 1;
              sout       <= d_i[XLEN-1];
              sout_valid <= 1'b1;
              cnt        <= CNT_W'(1);
            end else begin
              ecnt <= ecnt - EC_W'(1);
            end
          end
          S_UNLOAD: begin
            if (unload_done) begin
              sout       <= 1'b0;
              sout_valid <= 1'b0;
              cnt        <= '0;
            end else begin
              sout <= osh[XLEN-1];
              osh  <= osh << 1;
              cnt  <= cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SERIAL_PARITY_EN
  always_ff @(posedge clk12MHz) begin
    if (rst)                                      err <= 1'b0;
    else if (!abort && frame_done && !parity_ok)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nanov_serial_harness.sv
// Directed bench for nanov_serial_harness (default build, XLEN=32, OP_W=4, EXEC_CYCLES=32).
module tb_nanov_serial_harness;

  localparam int XLEN = 32;
  localparam int E    = 32;

  logic        clk12MHz = 1'b0;
  logic        rst, sin, sin_valid, abort;
  logic [3:0]  op_o;
  logic [31:0] a_o, b_o, d_i;
  logic        start_o, sout, sout_valid, busy, ovr, err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  bit early;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          gap;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vecs[5];

  nanov_serial_harness #(.XLEN(32), .OP_W(4), .EXEC_CYCLES(E)) dut (
    .clk12MHz(clk12MHz), .rst(rst), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .op_o(op_o), .a_o(a_o), .b_o(b_o), .start_o(start_o), .d_i(d_i),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .ovr(ovr), .err(err),
    .state_dbg(state_dbg)
  );

  // Core model: adder, opcode ignored
  assign d_i = a_o + b_o;

  always #5 clk12MHz = ~clk12MHz;

  task automatic tick();
    @(posedge clk12MHz);
    #1;
  endtask

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit gap);
    logic [67:0] fr;
    fr = {op, a, b};
    early = 1'b0;
    for (int i = 67; i >= 0; i--) begin
      sin = fr[i];
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      sin = 1'b0;
      if (i != 0) begin
        if (start_o) early = 1'b1;
        if (gap && ((68 - i) % 7 == 0)) begin
          repeat (5) begin
            tick();
            if (start_o) early = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic frame_checks(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("start_after_last_bit", start_o, 1);
    chk("op_o", op_o, op);
    chk("a_o", a_o, a);
    chk("b_o", b_o, b);
    chk("no_early_start", early, 0);
    chk("busy_exec", busy, 1);
  endtask

  task automatic exec_wait(input bit pulse);
    for (int k = 0; k <= E; k++) begin
      if (k == E) chk("no_sout_before_latency", sout_valid, 0);
      if (pulse && (k == 3 || k == 7)) begin
        sin = 1'b1;
        sin_valid = 1'b1;
      end
      tick();
      sin_valid = 1'b0;
      sin = 1'b0;
      if (k == 0) chk("start_one_cycle", start_o, 0);
    end
  endtask

  task automatic unload(input int abort_at);
    logic [31:0] res;
    bit          gap_seen;
    res = '0;
    gap_seen = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_sout_valid", sout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_state", state_dbg, 0);
        chk("abort_keeps_a", a_o, 32'h1);
        chk("abort_keeps_ovr", ovr, 1);
        return;
      end
      if (sout_valid !== 1'b1) gap_seen = 1'b1;
      res = {res[30:0], sout};
      tick();
    end
    chk("sout_valid_contiguous", gap_seen, 0);
    chk("sout_result", res, exp_q.pop_front());
    chk("end_sout_valid", sout_valid, 0);
    chk("end_sout", sout, 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    vecs[0] = '{4'h0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003};
    vecs[1] = '{4'h0, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0003};
    vecs[2] = '{4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE};
    vecs[3] = '{4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568};
    vecs[4] = '{4'h5, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0001};

    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_op_o", op_o, 0);
    chk("rst_a_o", a_o, 0);
    chk("rst_b_o", b_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_err", err, 0);
    chk("rst_state", state_dbg, 0);

    // Back-to-back frames: each new frame starts the cycle after the previous last sout bit
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].exp_d);
      send_frame(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].gap);
      frame_checks(vecs[v].op, vecs[v].a, vecs[v].b);
      exec_wait(1'b0);
      unload(-1);
    end
    chk("no_ovr_yet", ovr, 0);

    // sin_valid during EXEC: flagged, result unaffected
    exp_q.push_back(32'h3);
    send_frame(4'h0, 32'h1, 32'h2, 1'b0);
    frame_checks(4'h0, 32'h1, 32'h2);
    exec_wait(1'b1);
    chk("ovr_set", ovr, 1);
    unload(-1);

    // Abort on the 10th UNLOAD cycle
    send_frame(4'h0, 32'h1, 32'h2, 1'b0);
    frame_checks(4'h0, 32'h1, 32'h2);
    exec_wait(1'b0);
    unload(9);

    // Reset mid-LOAD
    for (int i = 0; i < 20; i++) begin
      sin = i[0];
      sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    chk("midload_busy", busy, 1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst2_op_o", op_o, 0);
    chk("rst2_a_o", a_o, 0);
    chk("rst2_b_o", b_o, 0);
    chk("rst2_sout", sout, 0);
    chk("rst2_sout_valid", sout_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_ovr", ovr, 0);
    chk("rst2_state", state_dbg, 0);

    exp_q.push_back(32'h3);
    send_frame(4'h0, 32'h1, 32'h2, 1'b0);
    frame_checks(4'h0, 32'h1, 32'h2);
    exec_wait(1'b0);
    unload(-1);
    chk("err_default_build", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
